pilha_parametrizada: RTL and testbench
======================================

# pilha_parametrizada

Parametrised LIFO stack between the control unit (UC) and the ALU (ULA) for operand and return-address storage. Generalises the fixed 16x16 stack: width and depth are parameters, full/empty/occupancy status is provided, overflow/underflow are detected, and push and pop in the same cycle are supported. Output data is registered, with a valid strobe.

## Interface
- `WIDTH`, 16: stored word width in bits.
- `DEPTH`, 16: number of entries; must be ≥2.
- `ULA_WIDTH`, 32: width of the ALU data input; only the low `WIDTH` bits are stored.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `push`  in  1  write selected source onto the stack this cycle.
- `pop`  in  1  read the top entry this cycle.
- `controle_pilha`  in  1  source select: 0 selects `din_UC`, 1 selects `din_ULA`.
- `din_UC`  in  `WIDTH`  control-unit data.
- `din_ULA`  in  `ULA_WIDTH`  ALU data; bits above `WIDTH` are ignored.
- `dout`  out  `WIDTH`  registered popped value; holds its value between pops.
- `dout_valid`  out  1  one-cycle pulse: `dout` was updated by a pop.
- `full`  out  1  count == `DEPTH`.
- `empty`  out  1  count == 0.
- `count`  out  `$clog2(DEPTH+1)`  current occupancy.
- `overflow`  out  1  push rejected because the stack was full.
- `underflow`  out  1  pop rejected because the stack was empty.
- `err_clr`  in  1  clears sticky errors. Present only with `PILHA_ERR_STICKY_EN`.

## Operation
- Storage: `DEPTH` x `WIDTH` array. `count` is the top pointer; the top entry is at index `count-1`.
- Push only, not full: `mem[count]` ← selected data and `count`+1.
- Push only, full: no write and `count` unchanged; `overflow` asserted.
- Pop only, not empty: `dout` ← `mem[count-1]` and `count`−1; `dout_valid` pulses.
- Pop only, empty: `dout` holds, `dout_valid` stays 0 and `count` stays 0; `underflow` asserted.
- Push and pop together, not empty (including full): `dout` ← `mem[count-1]`, then `mem[count-1]` ← new data. `count` unchanged, `dout_valid` pulses, no overflow.
- Push and pop together, empty: bypass. `dout` ← selected data, `dout_valid` pulses, no write, `count` stays 0, no underflow.
- No operation: all state holds.
- ALU data is truncated to `din_ULA[WIDTH-1:0]`; there is no sign or zero extension.
- Array contents are not reset. Reading an unwritten slot is not possible because pops are gated by `count`.

## Timing
- All state updates on the rising edge of `clk`.
- Pop latency is 1 cycle: `dout` and `dout_valid` are valid the cycle after `pop` is sampled.
- `full`, `empty` and `count` reflect the registered count. Status after an edge is visible in the same cycle, with no extra delay.
- `overflow` and `underflow` are registered and appear 1 cycle after the offending request.
- Reset, asynchronous on `rst`=0, sets: `count`=0, `empty`=1, `full`=0, `dout`=0, `dout_valid`=0, `overflow`=0, `underflow`=0.
- Reset asserted mid-operation aborts any in-flight request. No write from that cycle lands.
- Deassertion is synchronous to `clk` at system level; the block needs no internal synchroniser.
- No internal FSM: `count` is the only control state. Its legal range is 0..`DEPTH` and it never wraps.

## Configuration
- Macro: `PILHA_ERR_STICKY_EN`.
- Defined:
  - `overflow` and `underflow` are sticky; once set they stay 1.
  - `err_clr`=1 clears both on the next edge.
  - A new error in the same cycle as `err_clr` wins, so the flag stays 1.
- Undefined:
  - `err_clr` port is absent.
  - Each flag is a one-cycle pulse per rejected request.

## Structure
- Shared package `pilha_pkg` holds:
  - `SRC_UC`=1'b0 and `SRC_ULA`=1'b1;
  - default `WIDTH`, `DEPTH` and `ULA_WIDTH` constants;
  - a `pilha_op_t` encoding {NOP, PUSH, POP, SWAP} derived from {push, pop}.
- One sub-module, `pilha_mem`: a single-write, single-read register array with combinational read. Pointer, flag and error logic stay in the top module.

## Test plan
With `DEPTH`=4 and `WIDTH`=16:
- Reset then idle → `count`=0, `empty`=1, `full`=0, `dout`=0x0000, and no errors.
- Push UC values 0x1111, 0x2222, 0x3333, then three pops → `dout` is 0x3333, 0x2222, 0x1111 on consecutive cycles, each with `dout_valid`; ends with `empty`=1.
- Push 5 times → `full`=1 after the 4th push; the 5th push raises `overflow` and leaves `count`=4. Popping then returns the 4th value, not the 5th.
- `controle_pilha`=1 with `din_ULA`=0xDEADBEEF, then push and pop → `dout`=0xBEEF.
- Push 0x00AA, then push+pop with 0x00BB → `dout`=0x00AA and `count`=1. The next pop gives 0x00BB.
- Pop on empty → `underflow`=1 and `dout_valid`=0:
  - with `PILHA_ERR_STICKY_EN`, the flag holds until `err_clr`;
  - without it, the flag lasts one cycle.
- Separately, push+pop on empty with 0x0055 → `dout`=0x0055 and `count`=0.

Source files
------------

// File: rtl/pilha_pkg.sv
// Shared types and defaults for the parametrised LIFO stack.
// Source-select codes, default geometry and the push/pop operation encoding.
package pilha_pkg;

  localparam logic SRC_UC  = 1'b0;
  localparam logic SRC_ULA = 1'b1;

  localparam int PILHA_WIDTH_DEF     = 16;
  localparam int PILHA_DEPTH_DEF     = 16;
  localparam int PILHA_ULA_WIDTH_DEF = 32;

  // Encoding is exactly {push, pop}, so decoding is a plain cast.
  typedef enum logic [1:0] {
    NOP  = 2'b00,
    POP  = 2'b01,
    PUSH = 2'b10,
    SWAP = 2'b11
  } pilha_op_t;

  function automatic pilha_op_t op_decode(input logic i_push, input logic i_pop);
    return pilha_op_t'({i_push, i_pop});
  endfunction

endpackage

// File: rtl/pilha_mem.sv
// Storage array for the stack: one write port, one combinational read port.
// Contents are deliberately not reset.
module pilha_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/pilha_parametrizada.sv
// Parametrised LIFO stack between the control unit and the ALU, with status and error flags.
// Optional PILHA_ERR_STICKY_EN: overflow/underflow become sticky and gain an err_clr input.
module pilha_parametrizada
  import pilha_pkg::*;
#(
  parameter int WIDTH     = PILHA_WIDTH_DEF,
  parameter int DEPTH     = PILHA_DEPTH_DEF,
  parameter int ULA_WIDTH = PILHA_ULA_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
`ifdef PILHA_ERR_STICKY_EN
  input  logic                       err_clr,
`endif
  input  logic                       push,
  input  logic                       pop,
  input  logic                       controle_pilha,
  input  logic [WIDTH-1:0]           din_UC,
  input  logic [ULA_WIDTH-1:0]       din_ULA,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  // push/pop are single-cycle requests with no ready: each sampled edge is
  // either accepted, or rejected and reported on overflow/underflow a cycle later.
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_ovf;
  logic             r_unf;

  pilha_op_t        w_op;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_full;
  logic             w_empty;
  logic [AW-1:0]    w_top;
  logic [AW-1:0]    w_next_slot;
  logic [WIDTH-1:0] w_rdata;
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [CW-1:0]    w_count_nxt;
  logic [WIDTH-1:0] w_dout_nxt;
  logic             w_valid_nxt;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic             w_unused_ula;

  assign w_op         = op_decode(push, pop);
  assign w_sel_data   = (controle_pilha == SRC_ULA) ? din_ULA[WIDTH-1:0] : din_UC;
  assign w_unused_ula = ^din_ULA;
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign w_top        = AW'(r_count - CW'(1));
  assign w_next_slot  = AW'(r_count);

  always_comb begin
    w_we        = 1'b0;
    w_waddr     = w_next_slot;
    w_count_nxt = r_count;
    w_dout_nxt  = r_dout;
    w_valid_nxt = 1'b0;
    w_ovf_evt   = 1'b0;
    w_unf_evt   = 1'b0;
    case (w_op)
      PUSH: begin
        if (w_full) begin
          w_ovf_evt = 1'b1;
        end else begin
          w_we        = 1'b1;
          w_count_nxt = r_count + CW'(1);
        end
      end
      POP: begin
        if (w_empty) begin
          w_unf_evt = 1'b1;
        end else begin
          w_dout_nxt  = w_rdata;
          w_valid_nxt = 1'b1;
          w_count_nxt = r_count - CW'(1);
        end
      end
      SWAP: begin
        w_valid_nxt = 1'b1;
        // On an empty stack the new word passes straight through to dout.
        if (w_empty) begin
          w_dout_nxt = w_sel_data;
        end else begin
          w_dout_nxt = w_rdata;
          w_we       = 1'b1;
          w_waddr    = w_top;
        end
      end
      default: ;
    endcase
  end

  // Gating with rst keeps a request in the reset cycle from landing in the array.
  pilha_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we & rst),
    .i_waddr (w_waddr),
    .i_wdata (w_sel_data),
    .i_raddr (w_top),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_dout  <= w_dout_nxt;
      r_valid <= w_valid_nxt;
`ifdef PILHA_ERR_STICKY_EN
      r_ovf   <= w_ovf_evt | (r_ovf & ~err_clr);
      r_unf   <= w_unf_evt | (r_unf & ~err_clr);
`else
      r_ovf   <= w_ovf_evt;
      r_unf   <= w_unf_evt;
`endif
    end
  end

  assign dout       = r_dout;
  assign dout_valid = r_valid;
  assign count      = r_count;
  assign full       = w_full;
  assign empty      = w_empty;
  assign overflow   = r_ovf;
  assign underflow  = r_unf;

endmodule

// File: tb/tb_pilha_parametrizada.sv
// Directed, table-driven bench for pilha_parametrizada with DEPTH=4, WIDTH=16.
// Works with or without PILHA_ERR_STICKY_EN defined.
module tb_pilha_parametrizada;

  localparam int WIDTH     = 16;
  localparam int DEPTH     = 4;
  localparam int ULA_WIDTH = 32;
  localparam int CW        = $clog2(DEPTH+1);

  logic                 clk;
  logic                 rst;
  logic                 err_clr;
  logic                 push;
  logic                 pop;
  logic                 controle_pilha;
  logic [WIDTH-1:0]     din_UC;
  logic [ULA_WIDTH-1:0] din_ULA;
  logic [WIDTH-1:0]     dout;
  logic                 dout_valid;
  logic                 full;
  logic                 empty;
  logic [CW-1:0]        count;
  logic                 overflow;
  logic                 underflow;

  int n_cmp;
  int n_fail;

  typedef struct {
    logic        p;
    logic        q;
    logic        c;
    logic [15:0] uc;
    logic [31:0] ula;
    logic [15:0] e_dout;
    logic        e_valid;
    int          e_count;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t vecs[$];

  pilha_parametrizada #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ULA_WIDTH (ULA_WIDTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
`ifdef PILHA_ERR_STICKY_EN
    .err_clr        (err_clr),
`endif
    .push           (push),
    .pop            (pop),
    .controle_pilha (controle_pilha),
    .din_UC         (din_UC),
    .din_ULA        (din_ULA),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .full           (full),
    .empty          (empty),
    .count          (count),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic p, input logic q, input logic c,
                       input logic [15:0] uc, input logic [31:0] ula);
    @(negedge clk);
    push = p; pop = q; controle_pilha = c; din_UC = uc; din_ULA = ula;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] e_dout, input logic e_valid,
                           input int e_count, input logic e_ovf, input logic e_unf);
    chk({tag, " dout"}, 32'(dout), 32'(e_dout));
    chk({tag, " dout_valid"}, 32'(dout_valid), 32'(e_valid));
    chk({tag, " count"}, 32'(count), 32'(e_count));
    chk({tag, " full"}, 32'(full), 32'(e_count == DEPTH));
    chk({tag, " empty"}, 32'(empty), 32'(e_count == 0));
    chk({tag, " overflow"}, 32'(overflow), 32'(e_ovf));
    chk({tag, " underflow"}, 32'(underflow), 32'(e_unf));
  endtask

  task automatic add(input logic p, input logic q, input logic c, input logic [15:0] uc,
                     input logic [31:0] ula, input logic [15:0] e_dout, input logic e_valid,
                     input int e_count, input logic e_ovf, input logic e_unf);
    vec_t v;
    v = '{p, q, c, uc, ula, e_dout, e_valid, e_count, e_ovf, e_unf};
    vecs.push_back(v);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(vecs[i].p, vecs[i].q, vecs[i].c, vecs[i].uc, vecs[i].ula);
      check_all($sformatf("v%0d", i), vecs[i].e_dout, vecs[i].e_valid,
                vecs[i].e_count, vecs[i].e_ovf, vecs[i].e_unf);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1'b0; err_clr = 1'b0;
    push = 1'b0; pop = 1'b0; controle_pilha = 1'b0; din_UC = '0; din_ULA = '0;

    //   p  q  c  uc        ula            dout      v  cnt ovf unf
    add(0, 0, 0, 16'h0000, 32'h0,         16'h0000, 0, 0,  0,  0); // 0 idle after reset
    add(1, 0, 0, 16'h1111, 32'h0,         16'h0000, 0, 1,  0,  0);
    add(1, 0, 0, 16'h2222, 32'h0,         16'h0000, 0, 2,  0,  0);
    add(1, 0, 0, 16'h3333, 32'h0,         16'h0000, 0, 3,  0,  0);
    add(0, 1, 0, 16'h0000, 32'h0,         16'h3333, 1, 2,  0,  0);
    add(0, 1, 0, 16'h0000, 32'h0,         16'h2222, 1, 1,  0,  0);
    add(0, 1, 0, 16'h0000, 32'h0,         16'h1111, 1, 0,  0,  0);
    add(1, 0, 0, 16'hA001, 32'h0,         16'h1111, 0, 1,  0,  0);
    add(1, 0, 0, 16'hA002, 32'h0,         16'h1111, 0, 2,  0,  0);
    add(1, 0, 0, 16'hA003, 32'h0,         16'h1111, 0, 3,  0,  0);
    add(1, 0, 0, 16'hA004, 32'h0,         16'h1111, 0, 4,  0,  0);
    add(1, 0, 0, 16'hA005, 32'h0,         16'h1111, 0, 4,  1,  0); // 11 overflow
    add(0, 1, 0, 16'h0000, 32'h0,         16'hA004, 1, 3,  0,  0); // 12 not the 5th value
    add(0, 1, 0, 16'h0000, 32'h0,         16'hA003, 1, 2,  0,  0);
    add(0, 1, 0, 16'h0000, 32'h0,         16'hA002, 1, 1,  0,  0);
    add(0, 1, 0, 16'h0000, 32'h0,         16'hA001, 1, 0,  0,  0);
    add(1, 0, 1, 16'h7777, 32'hDEADBEEF,  16'hA001, 0, 1,  0,  0); // 16 ALU source
    add(0, 1, 0, 16'h0000, 32'h0,         16'hBEEF, 1, 0,  0,  0);
    add(1, 0, 0, 16'h00AA, 32'hFFFF0000,  16'hBEEF, 0, 1,  0,  0);
    add(1, 1, 0, 16'h00BB, 32'h0,         16'h00AA, 1, 1,  0,  0); // 19 push+pop
    add(0, 1, 0, 16'h0000, 32'h0,         16'h00BB, 1, 0,  0,  0);
    add(1, 1, 0, 16'h0055, 32'h0,         16'h0055, 1, 0,  0,  0); // 21 bypass on empty
    add(0, 0, 0, 16'h0000, 32'h0,         16'h0055, 0, 0,  0,  0);
    add(1, 0, 0, 16'h0B01, 32'h0,         16'h0055, 0, 1,  0,  0);
    add(1, 0, 0, 16'h0B02, 32'h0,         16'h0055, 0, 2,  0,  0);
    add(1, 0, 0, 16'h0B03, 32'h0,         16'h0055, 0, 3,  0,  0);
    add(1, 0, 0, 16'h0B04, 32'h0,         16'h0055, 0, 4,  0,  0);
    add(1, 1, 0, 16'h0C01, 32'h0,         16'h0B04, 1, 4,  0,  0); // 27 push+pop when full
    add(0, 1, 0, 16'h0000, 32'h0,         16'h0C01, 1, 3,  0,  0);
    add(0, 1, 0, 16'h0000, 32'h0,         16'h0B03, 1, 2,  0,  0);
    add(0, 1, 0, 16'h0000, 32'h0,         16'h0B02, 1, 1,  0,  0);
    add(0, 1, 0, 16'h0000, 32'h0,         16'h0B01, 1, 0,  0,  0);
    add(1, 1, 1, 16'h9999, 32'hCAFE1234,  16'h1234, 1, 0,  0,  0); // 32 ALU bypass

    // Reset state, checked before any clocked activity.
    #12;
    check_all("reset", 16'h0000, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    run_vecs(0, 11);

    // Overflow flag lifetime.
    drive(0, 0, 0, 16'h0, 32'h0);
`ifdef PILHA_ERR_STICKY_EN
    check_all("ovf_hold", 16'h1111, 1'b0, 4, 1'b1, 1'b0);
    err_clr = 1'b1;
    drive(0, 0, 0, 16'h0, 32'h0);
    err_clr = 1'b0;
    check_all("ovf_clr", 16'h1111, 1'b0, 4, 1'b0, 1'b0);
`else
    check_all("ovf_pulse", 16'h1111, 1'b0, 4, 1'b0, 1'b0);
`endif

    run_vecs(12, 32);

    // Underflow on empty: dout holds, no valid.
    drive(0, 1, 0, 16'h0, 32'h0);
    check_all("unf", 16'h1234, 1'b0, 0, 1'b0, 1'b1);
    drive(0, 0, 0, 16'h0, 32'h0);
`ifdef PILHA_ERR_STICKY_EN
    check_all("unf_hold1", 16'h1234, 1'b0, 0, 1'b0, 1'b1);
    drive(0, 0, 0, 16'h0, 32'h0);
    check_all("unf_hold2", 16'h1234, 1'b0, 0, 1'b0, 1'b1);
    err_clr = 1'b1;
    drive(0, 1, 0, 16'h0, 32'h0);
    check_all("unf_clr_vs_new", 16'h1234, 1'b0, 0, 1'b0, 1'b1);
    drive(0, 0, 0, 16'h0, 32'h0);
    err_clr = 1'b0;
    check_all("unf_clr", 16'h1234, 1'b0, 0, 1'b0, 1'b0);
`else
    check_all("unf_pulse", 16'h1234, 1'b0, 0, 1'b0, 1'b0);
`endif

    // Reset asserted mid-operation while a push is requested.
    drive(1, 0, 0, 16'hD001, 32'h0);
    check_all("pre_rst", 16'h1234, 1'b0, 1, 1'b0, 1'b0);
    @(negedge clk);
    push = 1'b1; din_UC = 16'hD002; rst = 1'b0;
    #1;
    check_all("rst_async", 16'h0000, 1'b0, 0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_held", 16'h0000, 1'b0, 0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1; push = 1'b0;
    drive(0, 1, 0, 16'h0, 32'h0);
    check_all("post_rst_pop", 16'h0000, 1'b0, 0, 1'b0, 1'b1);
    drive(1, 0, 0, 16'hE001, 32'h0);
    drive(0, 1, 0, 16'h0, 32'h0);
    check_all("post_rst_lifo", 16'hE001, 1'b1, 0, 1'b0, 1'b0);
    drive(0, 0, 0, 16'h0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
